logic_gate_bank_pipe: RTL and testbench

Parametrised successor to the fixed quad 2-input gate parts in the 74-series logic library. It is a bank of CHANNELS identical FANIN-input gates with a run-time selectable function (OR/AND/XOR/NOR). Results pass through a STAGES-deep registered pipeline with valid/ready flow control and a transfer counter. It is the registered, streaming building block for the glue-logic models, replacing banks of loose combinational gate chips.

---
 rtl/logic_gate_pkg.sv | 43 ++++
 rtl/logic_pipe_stage.sv | 46 ++++
 rtl/logic_gate_bank_pipe.sv | 99 +++++++++
 tb/tb_logic_gate_bank_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared gate-function definitions for the gate bank pipeline.
package logic_gate_pkg;

  // Widest gate the reduction helper supports.
  localparam int unsigned MaxFanin = 8;

  typedef enum logic [1:0] {
    GATE_OR  = 2'd0,
    GATE_AND = 2'd1,
    GATE_XOR = 2'd2,
    GATE_NOR = 2'd3
  } gate_mode_e;

  // Reduce the low `fanin` bits of `bits` with the selected function.
  // Bits at or above `fanin` are ignored.
  function automatic logic gate_eval(input logic [MaxFanin-1:0] bits,
                                     input int unsigned fanin,
                                     input gate_mode_e mode);
    logic or_r;
    logic and_r;
    logic xor_r;
    logic res;
    or_r  = 1'b0;
    and_r = 1'b1;
    xor_r = 1'b0;
    for (int unsigned i = 0; i < MaxFanin; i++) begin
      if (i < fanin) begin
        or_r  = or_r | bits[i];
        and_r = and_r & bits[i];
        xor_r = xor_r ^ bits[i];
      end
    end
    case (mode)
      GATE_OR:  res = or_r;
      GATE_AND: res = and_r;
      GATE_XOR: res = xor_r;
      GATE_NOR: res = ~or_r;
      default:  res = or_r;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/data register slice of the result pipeline.
module logic_pipe_stage #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             up_valid_i,
  input  logic [Width-1:0] up_data_i,
  input  logic             advance_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             load;

  // An empty slice always loads; a full one loads only as it hands its beat on.
  always_comb begin
    load    = !valid_q || advance_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = up_valid_i;
      // Data only moves with a real beat, so idle input never disturbs it.
      if (up_valid_i) begin
        data_d = up_data_i;
      end
    end
  end

  // Slice state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/logic_gate_bank_pipe.sv
// Bank of CHANNELS FANIN-input gates with per-beat function select, followed by
// a STAGES-deep valid/ready pipeline and a completed-transfer counter.
module logic_gate_bank_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned FANIN    = 2,
  parameter int unsigned STAGES   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [CHANNELS*FANIN-1:0] in_data_i,
  input  logic [1:0]                mode_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [CHANNELS-1:0]       out_data_o,
  output logic [15:0]               xfer_count_o
);

  logic [CHANNELS-1:0] gate_res;
  logic [STAGES-1:0]   stg_valid;
  logic [STAGES-1:0]   stg_adv;
  logic [CHANNELS-1:0] stg_data [STAGES];
  logic [15:0]         xfer_q, xfer_d;

  // Evaluate every channel's gate on the current input beat.
  always_comb begin
    logic [MaxFanin-1:0] operand;
    operand  = '0;
    gate_res = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      operand             = '0;
      operand[FANIN-1:0]  = in_data_i[c*FANIN +: FANIN];
      gate_res[c]         = gate_eval(operand, FANIN, gate_mode_e'(mode_i));
    end
  end

  // Ready ripples back from the output: a stage advances when the next one loads.
  always_comb begin
    logic next_load;
    next_load = out_ready_i;
    stg_adv   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stg_adv[k] = next_load;
      next_load  = !stg_valid[k] || next_load;
    end
    in_ready_o = next_load;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                up_valid;
    logic [CHANNELS-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid_i;
      assign up_data  = gate_res;
    end else begin : g_body
      assign up_valid = stg_valid[k-1];
      assign up_data  = stg_data[k-1];
    end

    logic_pipe_stage #(
      .Width(CHANNELS)
    ) u_stage (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .up_valid_i(up_valid),
      .up_data_i (up_data),
      .advance_i (stg_adv[k]),
      .valid_o   (stg_valid[k]),
      .data_o    (stg_data[k])
    );
  end

  assign out_valid_o = stg_valid[STAGES-1];
  assign out_data_o  = stg_data[STAGES-1];

  // Count completed output handshakes, wrapping naturally at 16 bits.
  always_comb begin
    xfer_d = xfer_q;
    if (out_valid_o && out_ready_i) begin
      xfer_d = xfer_q + 16'd1;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xfer_q <= '0;
    end else begin
      xfer_q <= xfer_d;
    end
  end

  assign xfer_count_o = xfer_q;

endmodule

// File: tb/tb_logic_gate_bank_pipe.sv
// Directed, table-driven bench for logic_gate_bank_pipe (CHANNELS=4, FANIN=2, STAGES=2).
module tb_logic_gate_bank_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [15:0] xfer_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  logic [3:0] sb_q[$];
  logic       prev_stall = 1'b0;
  logic [3:0] prev_data  = 4'd0;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[6];

  logic_gate_bank_pipe #(
    .CHANNELS(4),
    .FANIN   (2),
    .STAGES  (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .mode_i      (mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .xfer_count_o(xfer_count)
  );

  always #5 clk = ~clk;

  // Bit-level reference for the 4x2-input bank.
  function automatic logic [3:0] ref_gate(input logic [7:0] d, input logic [1:0] m);
    logic [3:0] r;
    logic a, b;
    for (int c = 0; c < 4; c++) begin
      a = d[2*c];
      b = d[2*c+1];
      case (m)
        2'd0:    r[c] = a | b;
        2'd1:    r[c] = a & b;
        2'd2:    r[c] = a ^ b;
        default: r[c] = ~(a | b);
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one beat until accepted, with random downstream readiness each cycle.
  task automatic send_rand(input logic [7:0] d, input logic [1:0] m);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    for (int t = 0; t < 64 && !done; t++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      done = in_ready;
      tick();
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Scoreboard: order/content of every output, no spurious beats, stall stability.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          check("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(ref_gate(in_data, mode));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    int pop0;
    vecs[0] = '{data: 8'b00_01_10_11, mode: 2'd0, exp: 4'b0111};
    vecs[1] = '{data: 8'b00_01_10_11, mode: 2'd1, exp: 4'b0001};
    vecs[2] = '{data: 8'b00_01_10_11, mode: 2'd2, exp: 4'b0110};
    vecs[3] = '{data: 8'b00_01_10_11, mode: 2'd3, exp: 4'b1000};
    vecs[4] = '{data: 8'hFF,          mode: 2'd2, exp: 4'b0000};
    vecs[5] = '{data: 8'h00,          mode: 2'd3, exp: 4'b1111};

    // Reset held with a beat offered.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    mode      = 2'd0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_xfer", 32'(xfer_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) tick();
    check("rst_nothing_out", 32'(out_valid), 32'd0);

    // Function table with latency check on each beat.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      mode     = vecs[i].mode;
      tick();
      in_valid = 1'b0;
      in_data  = 8'hA5;
      check("lat_not_yet", 32'(out_valid), 32'd0);
      tick();
      check("lat_valid", 32'(out_valid), 32'd1);
      check("func", 32'(out_data), 32'(vecs[i].exp));
      tick();
    end
    check("xfer_after_table", 32'(xfer_count), 32'd6);

    // Back-to-back throughput.
    pop0 = n_pop;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i * 37);
      mode     = 2'(i % 4);
      #1;
      check("tput_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("tput_count", 32'(n_pop - pop0), 32'd20);
    check("xfer_after_tput", 32'(xfer_count), 32'd26);

    // Backpressure: two beats fill the pipe, third waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h1B;
    mode      = 2'd0;
    #1;
    check("bp_a_ready", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'hE4;
    mode    = 2'd1;
    #1;
    check("bp_b_ready", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h5A;
    mode    = 2'd2;
    #1;
    check("bp_full", 32'(in_ready), 32'd0);
    check("bp_head", 32'(out_data), 32'(ref_gate(8'h1B, 2'd0)));
    repeat (2) tick();
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_head_held", 32'(out_data), 32'(ref_gate(8'h1B, 2'd0)));
    out_ready = 1'b1;
    #1;
    check("bp_drain_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_second", 32'(out_data), 32'(ref_gate(8'hE4, 2'd1)));
    repeat (3) tick();
    check("xfer_after_bp", 32'(xfer_count), 32'd29);

    // Mode bound per beat, streaming then with random backpressure.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h01;
      mode     = (i % 2 == 0) ? 2'd0 : 2'd1;
      tick();
      if (i >= 1) check("alt_out", 32'(out_data), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) send_rand(8'h01, (i % 2 == 0) ? 2'd0 : 2'd1);
    out_ready = 1'b1;
    repeat (4) tick();
    check("sb_empty_alt", 32'(sb_q.size()), 32'd0);

    // Reset with two beats in flight and a beat offered during reset.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    mode      = 2'd0;
    repeat (2) tick();
    check("mid_full", 32'(out_valid), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_out_data", 32'(out_data), 32'd0);
    check("mid_xfer", 32'(xfer_count), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    repeat (3) tick();
    check("mid_nothing_out", 32'(out_valid), 32'd0);

    // Counter wrap: 65535 transfers, then one more.
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 8'(i);
      mode    = 2'(i >> 8);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("xfer_ffff", 32'(xfer_count), 32'h0000FFFF);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    mode     = 2'd2;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("xfer_wrap", 32'(xfer_count), 32'd0);
    check("sb_empty_end", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
